// File: rtl/cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clock_ctrl
// Brief    : CPU clock-enable controller for run / halt / single-step.
//            Optional step-button debouncer: `define STEP_DEBOUNCE_EN
// Revision : 1.0 - initial release
// ============================================================================
module cpu_clock_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CYCLE_CNT_W     = 32
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   slow_clk,
    input  logic                   run_req,
    input  logic                   step_btn,
    input  logic                   halt_req,
    output logic                   cpu_ce,
    output logic [1:0]             state,
    output logic                   halted,
    output logic [CYCLE_CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        S_HALT   = 2'b00,
        S_RUN    = 2'b01,
        S_STEP   = 2'b10,
        S_HLATCH = 2'b11
    } state_t;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic       slow_s1_q, slow_s2_q, slow_hist_q;
    logic [1:0] fill_q;
    logic       armed_q;
    logic       tick_q;
    logic       btn_s1_q, btn_s2_q;
    logic       step_hist_q;
    logic       w_step_lvl;
    logic       w_step_ev;

    state_t                 state_q, state_d;
    logic                   ce_d;
    logic                   cpu_ce_q;
    logic                   halted_q;
    logic [CYCLE_CNT_W-1:0] cycle_cnt_q;

    // Ticks are only armed once a settled low has been seen after reset, so a
    // slow_clk that is already high at release cannot produce a tick.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            slow_s1_q   <= 1'b0;
            slow_s2_q   <= 1'b0;
            slow_hist_q <= 1'b0;
            fill_q      <= 2'd0;
            armed_q     <= 1'b0;
            tick_q      <= 1'b0;
            btn_s1_q    <= 1'b0;
            btn_s2_q    <= 1'b0;
            step_hist_q <= 1'b0;
        end else begin
            slow_s1_q   <= slow_clk;
            slow_s2_q   <= slow_s1_q;
            slow_hist_q <= slow_s2_q;
            if (fill_q != 2'd2)
                fill_q <= fill_q + 2'd1;
            if ((fill_q == 2'd2) && !slow_s2_q)
                armed_q <= 1'b1;
            tick_q      <= slow_s2_q & ~slow_hist_q & armed_q;
            btn_s1_q    <= step_btn;
            btn_s2_q    <= btn_s1_q;
            step_hist_q <= w_step_lvl;
        end
    end

`ifdef STEP_DEBOUNCE_EN
    localparam int             DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

    logic            btn_prev_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            btn_lvl_q;

    // db_cnt_q counts consecutive equal synchronized samples held in btn_prev_q.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            btn_prev_q <= 1'b0;
            db_cnt_q   <= '0;
            btn_lvl_q  <= 1'b0;
        end else begin
            btn_prev_q <= btn_s2_q;
            if (btn_s2_q != btn_prev_q)
                db_cnt_q <= DB_W'(1);
            else if (db_cnt_q != DB_MAX)
                db_cnt_q <= db_cnt_q + DB_W'(1);
            if (db_cnt_q == DB_MAX)
                btn_lvl_q <= btn_prev_q;
        end
    end

    assign w_step_lvl = btn_lvl_q;
`else
    assign w_step_lvl = btn_s2_q;
`endif

    assign w_step_ev = w_step_lvl & ~step_hist_q;

    always_comb begin
        state_d = state_q;
        ce_d    = 1'b0;
        case (state_q)
            S_HALT: begin
                if (run_req)
                    state_d = S_RUN;
                else if (w_step_ev)
                    state_d = S_STEP;
            end
            S_RUN: begin
                if (halt_req) begin
                    state_d = S_HLATCH;
                end else begin
                    ce_d = tick_q;
                    if (!run_req)
                        state_d = S_HALT;
                end
            end
            S_STEP: begin
                // A tick coinciding with run_req is issued once, then RUN continues.
                if (halt_req) begin
                    state_d = S_HLATCH;
                end else if (tick_q) begin
                    ce_d    = 1'b1;
                    state_d = run_req ? S_RUN : S_HALT;
                end else if (run_req) begin
                    state_d = S_RUN;
                end
            end
            S_HLATCH: begin
                if (!run_req)
                    state_d = S_HALT;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= S_HALT;
            cpu_ce_q    <= 1'b0;
            halted_q    <= 1'b1;
            cycle_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cpu_ce_q <= ce_d;
            halted_q <= (state_d == S_HALT) || (state_d == S_HLATCH);
            if (ce_d)
                cycle_cnt_q <= cycle_cnt_q + CYCLE_CNT_W'(1);
        end
    end

    assign cpu_ce    = cpu_ce_q;
    assign state     = state_q;
    assign halted    = halted_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_clock_ctrl
// Brief    : Scoreboard bench for cpu_clock_ctrl (DEBOUNCE_CYCLES=4, CYCLE_CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_clock_ctrl;

    localparam int CW = 4;

    logic          clk_in   = 1'b0;
    logic          reset    = 1'b1;
    logic          slow_clk = 1'b0;
    logic          run_req  = 1'b0;
    logic          step_btn = 1'b0;
    logic          halt_req = 1'b0;
    logic          cpu_ce;
    logic [1:0]    state;
    logic          halted;
    logic [CW-1:0] cycle_cnt;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int            cyc;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          exp_q[$];
    logic [CW-1:0] exp_cnt = '0;

    cpu_clock_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CYCLE_CNT_W     (CW)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .slow_clk  (slow_clk),
        .run_req   (run_req),
        .step_btn  (step_btn),
        .halt_req  (halt_req),
        .cpu_ce    (cpu_ce),
        .state     (state),
        .halted    (halted),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: every cpu_ce pulse must match the next expected pulse.
    always @(negedge clk_in) begin
        if (cpu_ce) begin
            exp_t e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_ce: cpu_ce=1 at cycle %0d, required 0", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.cnt != cycle_cnt) begin
                    miscompares++;
                    $display("FAIL ce_pulse: got cycle %0d cnt %0d, required cycle %0d cnt %0d",
                             cyc, cycle_cnt, e.cyc, e.cnt);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic expect_ce();
        exp_cnt = exp_cnt + 1'b1;
        exp_q.push_back('{cyc + 4, exp_cnt});
    endtask

    task automatic slow_period(input bit want_ce);
        slow_clk = 1'b1;
        if (want_ce) expect_ce();
        wait_cyc(11);
        slow_clk = 1'b0;
        wait_cyc(11);
    endtask

    task automatic press_step();
`ifdef STEP_DEBOUNCE_EN
        step_btn = 1'b1; wait_cyc(1);
        step_btn = 1'b0; wait_cyc(1);
        step_btn = 1'b1; wait_cyc(10);
        step_btn = 1'b0;
`else
        step_btn = 1'b1; wait_cyc(3);
        step_btn = 1'b0;
`endif
        wait_cyc(12);
    endtask

    initial begin
        // Reset state
        wait_cyc(2);
        check("rst_state", state, 0);
        check("rst_halted", halted, 1);
        check("rst_ce", cpu_ce, 0);
        check("rst_cnt", cycle_cnt, 0);
        reset = 1'b0;
        wait_cyc(5);

        // Free run: one pulse per slow_clk rise, counter wraps after 16
        run_req = 1'b1;
        wait_cyc(1);
        check("run_state", state, 1);
        check("run_halted", halted, 0);
        for (int i = 0; i < 17; i++) slow_period(1'b1);
        check("wrap_cnt", cycle_cnt, 1);
        run_req = 1'b0;
        wait_cyc(1);
        check("halt_state", state, 0);
        check("halt_halted", halted, 1);

        // Single step
        press_step();
        check("step_state", state, 2);
        slow_period(1'b1);
        check("step_done_state", state, 0);
        check("step_done_cnt", cycle_cnt, 2);

        // halt_req coincident with tick
        run_req = 1'b1;
        wait_cyc(1);
        slow_clk = 1'b1;
        wait_cyc(3);
        halt_req = 1'b1;
        wait_cyc(1);
        halt_req = 1'b0;
        check("hlatch_state", state, 3);
        check("hlatch_halted", halted, 1);
        wait_cyc(7);
        slow_clk = 1'b0;
        wait_cyc(11);
        slow_period(1'b0);
        check("hlatch_hold", state, 3);
        run_req = 1'b0;
        wait_cyc(1);
        check("hlatch_exit", state, 0);

        // Reset while waiting in STEP cancels the step
        press_step();
        check("step2_state", state, 2);
        wait_cyc(1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_cnt", cycle_cnt, 0);
        exp_cnt = '0;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(4);
        slow_period(1'b0);
        check("post_rst_state", state, 0);
        check("post_rst_cnt", cycle_cnt, 0);

        // run_req and slow_clk high through reset release
        reset    = 1'b1;
        run_req  = 1'b1;
        slow_clk = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(1);
        check("rel_run_state", state, 1);
        wait_cyc(10);
        slow_clk = 1'b0;
        wait_cyc(11);
        slow_period(1'b1);
        check("rel_run_cnt", cycle_cnt, 1);
        run_req = 1'b0;
        wait_cyc(10);

        check("pending_ce", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
